// File: rtl/ysyx_22041207_axi_rd_bridge_pkg.sv
// Shared AXI encodings, FSM state type and size helpers for the simple-port AXI read bridge.
package ysyx_22041207_axi_rd_bridge_pkg;

  // AXI burst type for the single-beat request (INCR with len 0 is one beat).
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Full-beat transfer size (2^3 = 8 bytes); narrowing happens on the returned beat.
  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

  // AXI read response codes; anything other than OKAY is reported as an error.
  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  // Bridge FSM: accept, address phase, data phase, hold result for the requester.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RESP = 2'd3
  } rd_state_e;

  // Byte masks for each legal request size.
  localparam logic [63:0] MASK_1B = 64'h0000_0000_0000_00FF;
  localparam logic [63:0] MASK_2B = 64'h0000_0000_0000_FFFF;
  localparam logic [63:0] MASK_4B = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] MASK_8B = 64'hFFFF_FFFF_FFFF_FFFF;

  // Only power-of-two byte counts up to one beat are meaningful requests.
  function automatic logic size_legal(input logic [7:0] size);
    return (size == 8'd1) || (size == 8'd2) || (size == 8'd4) || (size == 8'd8);
  endfunction

endpackage

// File: rtl/ysyx_22041207_rdata_align.sv
// Right-justifies the addressed bytes of a returned beat and zero-extends them to the request size.
module ysyx_22041207_rdata_align
  import ysyx_22041207_axi_rd_bridge_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [2:0]        i_offset,
  input  logic [7:0]        i_size,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_mask;

  // Shift the addressed byte down to bit 0; bytes past the end of the beat shift in as zero.
  always_comb begin
    w_shifted = i_rdata >> {i_offset, 3'b000};
    case (i_size)
      8'd1:    w_mask = DATA_W'(MASK_1B);
      8'd2:    w_mask = DATA_W'(MASK_2B);
      8'd4:    w_mask = DATA_W'(MASK_4B);
      default: w_mask = DATA_W'(MASK_8B);
    endcase
    o_data = w_shifted & w_mask;
  end

endmodule

// File: rtl/ysyx_22041207_axi_rd_bridge.sv
// Simple read port to single-beat AXI4 read bridge: one outstanding request, result held until taken.
module ysyx_22041207_axi_rd_bridge
  import ysyx_22041207_axi_rd_bridge_pkg::*;
#(
  parameter int RW_DATA_WIDTH  = 64,
  parameter int RW_ADDR_WIDTH  = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 1,
  parameter int AXI_RD_ID      = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // simple read port
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  input  logic [RW_ADDR_WIDTH-1:0]  r_addr_i,
  input  logic [7:0]                r_size_i,
  output logic [RW_DATA_WIDTH-1:0]  r_data_o,
  output logic                      r_data_valid_o,
  input  logic                      r_data_ready_i,
  output logic                      r_err_o,
  // AXI AR channel
  output logic                      axi_ar_valid_o,
  input  logic                      axi_ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_ar_id_o,
  output logic [7:0]                axi_ar_len_o,
  output logic [2:0]                axi_ar_size_o,
  output logic [1:0]                axi_ar_burst_o,
  output logic [AXI_USER_WIDTH-1:0] axi_ar_user_o,
  // AXI R channel
  input  logic                      axi_r_valid_i,
  output logic                      axi_r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0] axi_r_data_i,
  input  logic [1:0]                axi_r_resp_i,
  input  logic                      axi_r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_r_id_i
);

  rd_state_e                 r_state;
  rd_state_e                 w_state_nxt;
  logic                      w_accept;
  logic                      w_size_ok;
  logic [AXI_ADDR_WIDTH-1:0] r_ar_addr;
  logic [2:0]                r_offset;
  logic [7:0]                r_size;
  logic [RW_DATA_WIDTH-1:0]  r_data;
  logic                      r_err;
  logic [AXI_DATA_WIDTH-1:0] w_aligned;
  logic                      w_unused;

  // Single-beat transfers carry no useful LAST/ID information.
  assign w_unused = ^{axi_r_last_i, axi_r_id_i};

  assign w_size_ok = size_legal(r_size_i);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic and per-state handshake decode.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    axi_ar_valid_o = 1'b0;
    axi_r_ready_o  = 1'b0;
    r_data_valid_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // rst_n gates the accept so r_ready_o is low while reset is held.
        w_accept = r_valid_i & rst_n;
        if (w_accept) w_state_nxt = w_size_ok ? ST_AR : ST_RESP;
      end
      ST_AR: begin
        axi_ar_valid_o = 1'b1;
        if (axi_ar_ready_i) w_state_nxt = ST_R;
      end
      ST_R: begin
        axi_r_ready_o = 1'b1;
        if (axi_r_valid_i) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        r_data_valid_o = 1'b1;
        if (r_data_ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign r_ready_o = w_accept;

  // Latch the request on accept; the AR address is beat aligned, the offset kept for alignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ar_addr <= '0;
      r_offset  <= '0;
      r_size    <= '0;
    end else if (w_accept) begin
      r_ar_addr <= AXI_ADDR_WIDTH'({r_addr_i[RW_ADDR_WIDTH-1:3], 3'b000});
      r_offset  <= r_addr_i[2:0];
      r_size    <= r_size_i;
    end
  end

  ysyx_22041207_rdata_align #(
    .DATA_W (AXI_DATA_WIDTH)
  ) u_align (
    .i_rdata  (axi_r_data_i),
    .i_offset (r_offset),
    .i_size   (r_size),
    .o_data   (w_aligned)
  );

  // Capture the result: immediate error for an illegal size, else the aligned beat and its status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_err  <= 1'b0;
    end else if (w_accept && !w_size_ok) begin
      r_data <= '0;
      r_err  <= 1'b1;
    end else if ((r_state == ST_R) && axi_r_valid_i) begin
      r_data <= RW_DATA_WIDTH'(w_aligned);
      r_err  <= (axi_r_resp_i != AXI_RESP_OKAY);
    end
  end

  assign r_data_o       = r_data;
  assign r_err_o        = r_err;
  assign axi_ar_addr_o  = r_ar_addr;
  assign axi_ar_id_o    = AXI_ID_WIDTH'(AXI_RD_ID);
  assign axi_ar_len_o   = 8'd0;
  assign axi_ar_size_o  = AXI_SIZE_8B;
  assign axi_ar_burst_o = AXI_BURST_INCR;
  assign axi_ar_user_o  = '0;

endmodule

// File: tb/tb_ysyx_22041207_axi_rd_bridge.sv
// Directed bench for the AXI read bridge; the bench plays both the requester and the AXI slave.
module tb_ysyx_22041207_axi_rd_bridge;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [63:0] RD_BEAT     = 64'h1122_3344_5566_7788;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r_valid_i;
  logic        r_ready_o;
  logic [63:0] r_addr_i;
  logic [7:0]  r_size_i;
  logic [63:0] r_data_o;
  logic        r_data_valid_o;
  logic        r_data_ready_i;
  logic        r_err_o;
  logic        axi_ar_valid_o;
  logic        axi_ar_ready_i;
  logic [63:0] axi_ar_addr_o;
  logic [3:0]  axi_ar_id_o;
  logic [7:0]  axi_ar_len_o;
  logic [2:0]  axi_ar_size_o;
  logic [1:0]  axi_ar_burst_o;
  logic [0:0]  axi_ar_user_o;
  logic        axi_r_valid_i;
  logic        axi_r_ready_o;
  logic [63:0] axi_r_data_i;
  logic [1:0]  axi_r_resp_i;
  logic        axi_r_last_i;
  logic [3:0]  axi_r_id_i;

  int checks = 0;
  int errors = 0;
  int ar_hs  = 0;
  int ar_cyc = 0;
  int acc_cnt = 0;

  ysyx_22041207_axi_rd_bridge dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .r_valid_i      (r_valid_i),
    .r_ready_o      (r_ready_o),
    .r_addr_i       (r_addr_i),
    .r_size_i       (r_size_i),
    .r_data_o       (r_data_o),
    .r_data_valid_o (r_data_valid_o),
    .r_data_ready_i (r_data_ready_i),
    .r_err_o        (r_err_o),
    .axi_ar_valid_o (axi_ar_valid_o),
    .axi_ar_ready_i (axi_ar_ready_i),
    .axi_ar_addr_o  (axi_ar_addr_o),
    .axi_ar_id_o    (axi_ar_id_o),
    .axi_ar_len_o   (axi_ar_len_o),
    .axi_ar_size_o  (axi_ar_size_o),
    .axi_ar_burst_o (axi_ar_burst_o),
    .axi_ar_user_o  (axi_ar_user_o),
    .axi_r_valid_i  (axi_r_valid_i),
    .axi_r_ready_o  (axi_r_ready_o),
    .axi_r_data_i   (axi_r_data_i),
    .axi_r_resp_i   (axi_r_resp_i),
    .axi_r_last_i   (axi_r_last_i),
    .axi_r_id_i     (axi_r_id_i)
  );

  always #5 clk = ~clk;

  // Count AR handshakes, cycles with AR valid, and accepted requests at each active edge.
  always @(posedge clk) begin
    if (axi_ar_valid_o && axi_ar_ready_i) ar_hs <= ar_hs + 1;
    if (axi_ar_valid_o) ar_cyc <= ar_cyc + 1;
    if (r_valid_i && r_ready_o) acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle_inputs();
    r_valid_i      = 1'b0;
    r_addr_i       = '0;
    r_size_i       = '0;
    r_data_ready_i = 1'b0;
    axi_ar_ready_i = 1'b0;
    axi_r_valid_i  = 1'b0;
    axi_r_data_i   = '0;
    axi_r_resp_i   = RESP_OKAY;
    axi_r_last_i   = 1'b1;
    axi_r_id_i     = '0;
  endtask

  // One complete read with programmable stalls; checks alignment, stability and handshake counts.
  task automatic run_read(input string name, input logic [63:0] addr, input logic [7:0] size,
                          input logic [1:0] resp, input int ar_wait, input int r_wait,
                          input int dr_wait, input logic exp_axi, input logic [63:0] exp_araddr,
                          input logic [63:0] exp_data, input logic exp_err);
    int hs0, arc0, acc0;
    hs0  = ar_hs;
    arc0 = ar_cyc;
    acc0 = acc_cnt;
    r_valid_i = 1'b1; r_addr_i = addr; r_size_i = size;
    #1;
    checks++;
    if (r_ready_o !== 1'b1) begin errors++; $display("FAIL %s accept got %b exp 1", name, r_ready_o); end
    @(negedge clk);
    r_valid_i = 1'b0; r_addr_i = '0; r_size_i = '0;
    if (exp_axi) begin
      for (int i = 0; i <= ar_wait; i++) begin
        checks++;
        if (axi_ar_valid_o !== 1'b1) begin errors++; $display("FAIL %s ar_valid got %b exp 1", name, axi_ar_valid_o); end
        checks++;
        if (axi_ar_addr_o !== exp_araddr) begin errors++; $display("FAIL %s ar_addr got %h exp %h", name, axi_ar_addr_o, exp_araddr); end
        if (i == ar_wait) axi_ar_ready_i = 1'b1;
        @(negedge clk);
      end
      axi_ar_ready_i = 1'b0;
      for (int i = 0; i <= r_wait; i++) begin
        checks++;
        if ({axi_r_ready_o, axi_ar_valid_o, r_data_valid_o} !== 3'b100) begin
          errors++; $display("FAIL %s r_phase got rready/arvalid/dvalid=%b exp 100", name, {axi_r_ready_o, axi_ar_valid_o, r_data_valid_o});
        end
        if (i == r_wait) begin axi_r_valid_i = 1'b1; axi_r_data_i = RD_BEAT; axi_r_resp_i = resp; end
        @(negedge clk);
      end
      axi_r_valid_i = 1'b0; axi_r_data_i = 64'hDEAD_BEEF_CAFE_F00D; axi_r_resp_i = RESP_DECERR;
    end
    for (int i = 0; i <= dr_wait; i++) begin
      checks++;
      if (r_data_valid_o !== 1'b1) begin errors++; $display("FAIL %s data_valid got %b exp 1", name, r_data_valid_o); end
      checks++;
      if (r_data_o !== exp_data) begin errors++; $display("FAIL %s data got %h exp %h", name, r_data_o, exp_data); end
      checks++;
      if (r_err_o !== exp_err) begin errors++; $display("FAIL %s err got %b exp %b", name, r_err_o, exp_err); end
      checks++;
      if (axi_ar_valid_o !== 1'b0) begin errors++; $display("FAIL %s ar_valid in resp got %b exp 0", name, axi_ar_valid_o); end
      if (i == dr_wait) r_data_ready_i = 1'b1;
      @(negedge clk);
    end
    r_data_ready_i = 1'b0;
    checks++;
    if (r_data_valid_o !== 1'b0) begin errors++; $display("FAIL %s data_valid after take got %b exp 0", name, r_data_valid_o); end
    checks++;
    if ((ar_hs - hs0) !== (exp_axi ? 1 : 0)) begin errors++; $display("FAIL %s ar_handshakes got %0d exp %0d", name, ar_hs - hs0, exp_axi ? 1 : 0); end
    checks++;
    if ((ar_cyc - arc0) !== (exp_axi ? ar_wait + 1 : 0)) begin errors++; $display("FAIL %s ar_valid_cycles got %0d exp %0d", name, ar_cyc - arc0, exp_axi ? ar_wait + 1 : 0); end
    checks++;
    if ((acc_cnt - acc0) !== 1) begin errors++; $display("FAIL %s accepts got %0d exp 1", name, acc_cnt - acc0); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ({r_ready_o, r_data_valid_o, r_err_o, axi_ar_valid_o, axi_r_ready_o} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {r_ready_o, r_data_valid_o, r_err_o, axi_ar_valid_o, axi_r_ready_o});
    end
    checks++;
    if ((r_data_o !== 64'h0) || (axi_ar_addr_o !== 64'h0)) begin
      errors++; $display("FAIL reset_data got data=%h araddr=%h exp 0", r_data_o, axi_ar_addr_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    r_valid_i = 1'b1; r_addr_i = 64'h8000_0040; r_size_i = 8'd8;
    #1;
    checks++;
    if (r_ready_o !== 1'b1) begin errors++; $display("FAIL reset_first_accept got %b exp 1", r_ready_o); end
    @(negedge clk);
    r_valid_i = 1'b0;
    checks++;
    if ((axi_ar_valid_o !== 1'b1) || (axi_ar_addr_o !== 64'h8000_0040)) begin
      errors++; $display("FAIL reset_pre_ar got valid=%b addr=%h exp 1 80000040", axi_ar_valid_o, axi_ar_addr_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({r_ready_o, r_data_valid_o, r_err_o, axi_ar_valid_o, axi_r_ready_o} !== 5'b0) begin
      errors++; $display("FAIL reset_mid_ar_ctrl got %b exp 00000", {r_ready_o, r_data_valid_o, r_err_o, axi_ar_valid_o, axi_r_ready_o});
    end
    checks++;
    if ((r_data_o !== 64'h0) || (axi_ar_addr_o !== 64'h0)) begin
      errors++; $display("FAIL reset_mid_ar_data got data=%h araddr=%h exp 0", r_data_o, axi_ar_addr_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({axi_ar_valid_o, axi_r_ready_o, r_data_valid_o} !== 3'b000) begin
      errors++; $display("FAIL reset_release_idle got %b exp 000", {axi_ar_valid_o, axi_r_ready_o, r_data_valid_o});
    end
    r_valid_i = 1'b1;
    #1;
    checks++;
    if (r_ready_o !== 1'b1) begin errors++; $display("FAIL reset_idle_accepts got %b exp 1", r_ready_o); end
    r_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_aligned();
    axi_ar_ready_i = 1'b1; axi_r_valid_i = 1'b1; axi_r_data_i = RD_BEAT; axi_r_resp_i = RESP_OKAY;
    r_valid_i = 1'b1; r_addr_i = 64'h8000_0008; r_size_i = 8'd8;
    #1;
    checks++;
    if (r_ready_o !== 1'b1) begin errors++; $display("FAIL aligned_accept got %b exp 1", r_ready_o); end
    @(negedge clk);
    r_valid_i = 1'b0;
    checks++;
    if (axi_ar_valid_o !== 1'b1) begin errors++; $display("FAIL aligned_ar_valid_n1 got %b exp 1", axi_ar_valid_o); end
    checks++;
    if (axi_ar_addr_o !== 64'h8000_0008) begin errors++; $display("FAIL aligned_araddr got %h exp 80000008", axi_ar_addr_o); end
    checks++;
    if ({axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o, axi_ar_id_o, axi_ar_user_o} !== {8'd0, 3'd3, 2'b01, 4'd0, 1'b0}) begin
      errors++; $display("FAIL aligned_ar_attrs got len=%0d size=%0d burst=%0d id=%0d user=%0d exp 0 3 1 0 0",
                         axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o, axi_ar_id_o, axi_ar_user_o);
    end
    @(negedge clk);
    checks++;
    if ({axi_r_ready_o, axi_ar_valid_o, r_data_valid_o} !== 3'b100) begin
      errors++; $display("FAIL aligned_r_n2 got %b exp 100", {axi_r_ready_o, axi_ar_valid_o, r_data_valid_o});
    end
    @(negedge clk);
    axi_ar_ready_i = 1'b0; axi_r_valid_i = 1'b0;
    checks++;
    if (r_data_valid_o !== 1'b1) begin errors++; $display("FAIL aligned_dvalid_n3 got %b exp 1", r_data_valid_o); end
    checks++;
    if ((r_data_o !== RD_BEAT) || (r_err_o !== 1'b0)) begin
      errors++; $display("FAIL aligned_data got %h err=%b exp %h err=0", r_data_o, r_err_o, RD_BEAT);
    end
    r_data_ready_i = 1'b1;
    @(negedge clk);
    r_data_ready_i = 1'b0;
    checks++;
    if (r_data_valid_o !== 1'b0) begin errors++; $display("FAIL aligned_dvalid_drop got %b exp 0", r_data_valid_o); end
  endtask

  task automatic test_subword();
    run_read("sub_off5_sz2", 64'h8000_0005, 8'd2, RESP_OKAY, 0, 0, 0, 1'b1, 64'h8000_0000, 64'h2233, 1'b0);
    run_read("sub_off4_sz2", 64'h8000_0004, 8'd2, RESP_OKAY, 0, 0, 0, 1'b1, 64'h8000_0000, 64'h3344, 1'b0);
    run_read("sub_off7_sz1", 64'h8000_0007, 8'd1, RESP_OKAY, 0, 0, 0, 1'b1, 64'h8000_0000, 64'h11, 1'b0);
    run_read("sub_off0_sz4", 64'h8000_0010, 8'd4, RESP_OKAY, 0, 0, 0, 1'b1, 64'h8000_0010, 64'h5566_7788, 1'b0);
  endtask

  task automatic test_misaligned();
    run_read("cross_off6_sz4", 64'h8000_0006, 8'd4, RESP_OKAY, 0, 0, 0, 1'b1, 64'h8000_0000, 64'h1122, 1'b0);
    run_read("cross_off3_sz8", 64'h8000_0103, 8'd8, RESP_OKAY, 0, 0, 0, 1'b1, 64'h8000_0100, 64'h0000_0011_2233_4455, 1'b0);
  endtask

  task automatic test_stalls();
    run_read("stall_5_3_4", 64'h8000_0018, 8'd4, RESP_OKAY, 5, 3, 4, 1'b1, 64'h8000_0018, 64'h5566_7788, 1'b0);
  endtask

  task automatic test_errors();
    run_read("err_slverr", 64'h8000_0020, 8'd8, RESP_SLVERR, 0, 1, 0, 1'b1, 64'h8000_0020, RD_BEAT, 1'b1);
    run_read("err_decerr", 64'h8000_0021, 8'd1, RESP_DECERR, 1, 0, 0, 1'b1, 64'h8000_0020, 64'h77, 1'b1);
    run_read("err_size3", 64'h8000_0030, 8'd3, RESP_OKAY, 0, 0, 2, 1'b0, 64'h0, 64'h0, 1'b1);
    run_read("err_size0", 64'h8000_0038, 8'd0, RESP_OKAY, 0, 0, 0, 1'b0, 64'h0, 64'h0, 1'b1);
    run_read("err_cleared", 64'h8000_0038, 8'd8, RESP_OKAY, 0, 0, 0, 1'b1, 64'h8000_0038, RD_BEAT, 1'b0);
  endtask

  task automatic test_back_to_back();
    int acc0, hs0;
    logic exp_rdy, exp_arv, exp_dv;
    acc0 = acc_cnt;
    hs0  = ar_hs;
    axi_ar_ready_i = 1'b1; axi_r_valid_i = 1'b1; axi_r_data_i = RD_BEAT; axi_r_resp_i = RESP_OKAY;
    r_data_ready_i = 1'b1;
    r_valid_i = 1'b1; r_addr_i = 64'h8000_0040; r_size_i = 8'd8;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) begin r_addr_i = 64'h8000_0044; r_size_i = 8'd4; end
      #1;
      exp_rdy = (c == 0) || (c == 4);
      exp_arv = (c == 1) || (c == 5);
      exp_dv  = (c == 3) || (c == 7);
      checks++;
      if (r_ready_o !== exp_rdy) begin errors++; $display("FAIL b2b_ready c%0d got %b exp %b", c, r_ready_o, exp_rdy); end
      checks++;
      if (axi_ar_valid_o !== exp_arv) begin errors++; $display("FAIL b2b_ar_valid c%0d got %b exp %b", c, axi_ar_valid_o, exp_arv); end
      checks++;
      if (r_data_valid_o !== exp_dv) begin errors++; $display("FAIL b2b_dvalid c%0d got %b exp %b", c, r_data_valid_o, exp_dv); end
      if (c == 1 || c == 5) begin
        checks++;
        if (axi_ar_addr_o !== ((c == 1) ? 64'h8000_0040 : 64'h8000_0040)) begin
          errors++; $display("FAIL b2b_araddr c%0d got %h exp 80000040", c, axi_ar_addr_o);
        end
      end
      if (c == 3 || c == 7) begin
        checks++;
        if (r_data_o !== ((c == 3) ? RD_BEAT : 64'h1122_3344)) begin
          errors++; $display("FAIL b2b_data c%0d got %h exp %h", c, r_data_o, (c == 3) ? RD_BEAT : 64'h1122_3344);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    checks++;
    if ((acc_cnt - acc0) !== 2) begin errors++; $display("FAIL b2b_accepts got %0d exp 2", acc_cnt - acc0); end
    checks++;
    if ((ar_hs - hs0) !== 2) begin errors++; $display("FAIL b2b_ar_handshakes got %0d exp 2", ar_hs - hs0); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_subword();
    test_misaligned();
    test_stalls();
    test_errors();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
